// File: rtl/traceback_if.sv
// Bus bundle for the traceback unit: direction-memory write port, start request,
// op stream and completion status.
interface traceback_if;
    localparam int unsigned N_PE = 64;
    localparam int unsigned AW   = 8;

    logic                 i_dir_we;
    logic [AW-1:0]        i_dir_addr;
    logic [N_PE-1:0]      i_dir_mask;
    logic [4*N_PE-1:0]    i_dir_data;

    logic                 i_tb_start;
    logic [5:0]           i_start_row;
    logic [9:0]           i_start_col;

    logic                 o_op_valid;
    logic [1:0]           o_op;
    logic                 i_op_ready;

    logic                 o_busy;
    logic                 o_done;
    logic                 o_err;
    logic [6:0]           o_end_row;
    logic [10:0]          o_end_col;
    logic [9:0]           o_op_count;

    modport master (
        output i_dir_we, i_dir_addr, i_dir_mask, i_dir_data,
        output i_tb_start, i_start_row, i_start_col, i_op_ready,
        input  o_op_valid, o_op, o_busy, o_done, o_err,
        input  o_end_row, o_end_col, o_op_count
    );

    modport slave (
        input  i_dir_we, i_dir_addr, i_dir_mask, i_dir_data,
        input  i_tb_start, i_start_row, i_start_col, i_op_ready,
        output o_op_valid, o_op, o_busy, o_done, o_err,
        output o_end_row, o_end_col, o_op_count
    );
endinterface

// File: rtl/traceback_unit.sv
// Affine-gap traceback: walks M/I/D direction words back from an end cell and
// streams one alignment op per visited cell over ready/valid.
module traceback_unit (
    input  logic        i_clk,
    input  logic        i_rst,
    traceback_if.slave  bus_if
);
    localparam int unsigned N_PE  = 64;
    localparam int unsigned DEPTH = 256;
    localparam int unsigned AW    = 8;
    localparam int unsigned WW    = 4 * N_PE;

    localparam logic [1:0] OP_M = 2'd0;
    localparam logic [1:0] OP_I = 2'd1;
    localparam logic [1:0] OP_D = 2'd2;

    typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_EMIT, ST_DONE} state_e;
    typedef enum logic [1:0] {MODE_M, MODE_I, MODE_D} mode_e;

    state_e             state_q, state_d;
    mode_e              mode_q, mode_d, nmode_q, nmode_d;
    logic signed [6:0]  r_q, r_d, r_nx;
    logic signed [10:0] c_q, c_d, c_nx;
    logic [9:0]         cnt_q, cnt_d;
    logic               stop_q, stop_d;
    logic               op_valid_q, op_valid_d;
    logic [1:0]         op_q, op_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic [WW-1:0]      mem_q [DEPTH];
    logic [AW-1:0]      rd_addr;
    logic [WW-1:0]      rd_line;
    logic [3:0]         rd_word;
    logic [1:0]         v_dir;
    logic [10:0]        start_sum;
    logic               start_oor;

    // Direction memory: masked per-PE write, never reset
    always_ff @(posedge i_clk) begin
        if (bus_if.i_dir_we) begin
            for (int p = 0; p < int'(N_PE); p++) begin
                if (bus_if.i_dir_mask[p]) begin
                    mem_q[bus_if.i_dir_addr][4*p +: 4] <= bus_if.i_dir_data[4*p +: 4];
                end
            end
        end
    end

    // Read path used only in FETCH, where r and c are both non-negative
    assign rd_addr   = AW'(r_q[5:0]) + AW'(c_q);
    assign rd_line   = mem_q[rd_addr];
    assign rd_word   = rd_line[{r_q[5:0], 2'b00} +: 4];
    assign v_dir     = rd_word[3:2];
    assign start_sum = 11'(bus_if.i_start_row) + 11'(bus_if.i_start_col);
    assign start_oor = start_sum > 11'(DEPTH - 1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_M;
            nmode_q    <= MODE_M;
            r_q        <= '0;
            c_q        <= '0;
            cnt_q      <= '0;
            stop_q     <= 1'b0;
            op_valid_q <= 1'b0;
            op_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            nmode_q    <= nmode_d;
            r_q        <= r_d;
            c_q        <= c_d;
            cnt_q      <= cnt_d;
            stop_q     <= stop_d;
            op_valid_q <= op_valid_d;
            op_q       <= op_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        nmode_d    = nmode_q;
        r_d        = r_q;
        c_d        = c_q;
        cnt_d      = cnt_q;
        stop_d     = stop_q;
        op_valid_d = 1'b0;
        op_d       = op_q;
        err_d      = 1'b0;
        r_nx       = r_q;
        c_nx       = c_q;

        case (state_q)
            ST_IDLE: begin
                if (bus_if.i_tb_start) begin
                    r_d     = 7'(bus_if.i_start_row);
                    c_d     = 11'(bus_if.i_start_col);
                    mode_d  = MODE_M;
                    cnt_d   = '0;
                    err_d   = start_oor;
                    state_d = start_oor ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: begin
                // Decode the word as it is read so the op is registered for EMIT
                state_d = ST_EMIT;
                if (mode_q == MODE_M && v_dir == 2'd3) begin
                    stop_d = 1'b1;
                end else begin
                    stop_d     = 1'b0;
                    op_valid_d = 1'b1;
                    if (mode_q == MODE_M && v_dir == 2'd0) begin
                        op_d    = OP_M;
                        nmode_d = MODE_M;
                    end else if (mode_q == MODE_I || (mode_q == MODE_M && v_dir == 2'd1)) begin
                        op_d    = OP_I;
                        nmode_d = rd_word[1] ? MODE_I : MODE_M;
                    end else begin
                        op_d    = OP_D;
                        nmode_d = rd_word[0] ? MODE_D : MODE_M;
                    end
                end
            end
            ST_EMIT: begin
                if (stop_q) begin
                    state_d = ST_DONE;
                end else if (bus_if.i_op_ready) begin
                    if (op_q != OP_I) r_nx = r_q - 7'sd1;
                    if (op_q != OP_D) c_nx = c_q - 11'sd1;
                    r_d     = r_nx;
                    c_d     = c_nx;
                    mode_d  = nmode_q;
                    cnt_d   = cnt_q + 10'd1;
                    state_d = (r_nx[6] || c_nx[10]) ? ST_DONE : ST_FETCH;
                end else begin
                    op_valid_d = op_valid_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    assign bus_if.o_op_valid = op_valid_q;
    assign bus_if.o_op       = op_q;
    assign bus_if.o_busy     = busy_q;
    assign bus_if.o_done     = done_q;
    assign bus_if.o_err      = err_q;
    assign bus_if.o_end_row  = r_q;
    assign bus_if.o_end_col  = c_q;
    assign bus_if.o_op_count = cnt_q;
endmodule
